// File: rtl/csoc_scan_ctrl.sv
// CSoC scan controller: sequences chain reset, shift and capture.
// Define CSOC_SCAN_SIG_EN to build the scan-out signature register.
module csoc_scan_ctrl #(
  parameter int NCHAINS = 8,
  parameter int MAX_LEN = 1024,
  parameter int CLK_DIV = 2,
  localparam int LEN_W = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_arg,
  input  logic               si_valid,
  output logic               si_ready,
  input  logic [NCHAINS-1:0] si_data,
  output logic               so_valid,
  input  logic               so_ready,
  output logic [NCHAINS-1:0] so_data,
  output logic               busy,
  output logic               done,
  output logic               csoc_clk,
  output logic               csoc_rstn,
  output logic               csoc_test_se,
  output logic               csoc_test_tm,
  output logic [NCHAINS-1:0] csoc_data_o,
  input  logic [NCHAINS-1:0] csoc_data_i,
  output logic [NCHAINS-1:0] sig
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_SHIFT = 2'd1;
  localparam logic [1:0] OP_CAP   = 2'd2;

  typedef enum logic [2:0] {
    IDLE, RST_LO, RST_HI, SH_WAIT,
    SH_LO, SH_HI, CAP_LO, CAP_HI
  } state_t;

  state_t             state, state_n;
  logic [PH_W-1:0]    ph, ph_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic               clk_n, rstn_n, se_n, tm_n;
  logic               sov_n, done_n;
  logic [NCHAINS-1:0] do_n, sod_n;
  logic               ph_end, cnt_end;

  assign ph_end    = (ph == '0);
  assign cnt_end   = (cnt == '0);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign si_ready  = (state == SH_WAIT) && !so_valid;

  always_comb begin
    state_n = state;
    ph_n    = ph;
    cnt_n   = cnt;
    clk_n   = csoc_clk;
    rstn_n  = csoc_rstn;
    se_n    = csoc_test_se;
    tm_n    = csoc_test_tm;
    do_n    = csoc_data_o;
    sov_n   = so_valid;
    sod_n   = so_data;
    done_n  = 1'b0;
    if (so_valid && so_ready) sov_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_RESET: begin
              state_n = RST_LO;
              ph_n    = PH_LAST;
              cnt_n   = cmd_arg;
              rstn_n  = 1'b0;
              clk_n   = 1'b0;
            end
            OP_SHIFT: begin
              state_n = SH_WAIT;
              cnt_n   = cmd_arg;
              se_n    = 1'b1;
              clk_n   = 1'b0;
            end
            OP_CAP: begin
              state_n = CAP_LO;
              ph_n    = PH_LAST;
              se_n    = 1'b0;
              clk_n   = 1'b0;
            end
            default: begin
              tm_n   = cmd_arg[0];
              done_n = 1'b1;
            end
          endcase
        end
      end
      RST_LO: begin
        if (ph_end) begin
          state_n = RST_HI;
          ph_n    = PH_LAST;
          clk_n   = 1'b1;
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      RST_HI: begin
        if (ph_end) begin
          clk_n = 1'b0;
          if (cnt_end) begin
            state_n = IDLE;
            rstn_n  = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n = RST_LO;
            cnt_n   = cnt - LEN_W'(1);
            ph_n    = PH_LAST;
          end
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      // csoc_clk stays low here until the so slot drains
      SH_WAIT: begin
        if (si_valid && si_ready) begin
          do_n    = si_data;
          state_n = SH_LO;
          ph_n    = PH_LAST;
        end
      end
      SH_LO: begin
        if (ph_end) begin
          sod_n   = csoc_data_i;
          sov_n   = 1'b1;
          clk_n   = 1'b1;
          state_n = SH_HI;
          ph_n    = PH_LAST;
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      SH_HI: begin
        if (ph_end) begin
          clk_n = 1'b0;
          if (cnt_end) begin
            state_n = IDLE;
            se_n    = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = SH_WAIT;
            cnt_n   = cnt - LEN_W'(1);
          end
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      CAP_LO: begin
        if (ph_end) begin
          state_n = CAP_HI;
          ph_n    = PH_LAST;
          clk_n   = 1'b1;
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      CAP_HI: begin
        if (ph_end) begin
          clk_n   = 1'b0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          ph_n = ph - PH_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      ph           <= '0;
      cnt          <= '0;
      csoc_clk     <= 1'b0;
      csoc_rstn    <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      csoc_data_o  <= '0;
      so_valid     <= 1'b0;
      so_data      <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      ph           <= ph_n;
      cnt          <= cnt_n;
      csoc_clk     <= clk_n;
      csoc_rstn    <= rstn_n;
      csoc_test_se <= se_n;
      csoc_test_tm <= tm_n;
      csoc_data_o  <= do_n;
      so_valid     <= sov_n;
      so_data      <= sod_n;
      done         <= done_n;
    end
  end

`ifdef CSOC_SCAN_SIG_EN
  logic               sig_clr, sig_smp;
  logic [NCHAINS-1:0] sig_rot;

  assign sig_clr = (state == IDLE) && cmd_valid && (cmd_op == OP_SHIFT);
  assign sig_smp = (state == SH_LO) && ph_end;
  assign sig_rot = (sig << 1) | (sig >> (NCHAINS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) sig <= '0;
    else if (sig_clr) sig <= '0;
    else if (sig_smp) sig <= sig_rot ^ csoc_data_i;
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// Randomized bench for csoc_scan_ctrl with a timeline model and loopback chains.
// Signature expectations follow CSOC_SCAN_SIG_EN.
module tb_csoc_scan_ctrl;
  localparam int NC = 8;
  localparam int ML = 1024;
  localparam int D  = 2;
  localparam int LW = $clog2(ML);
  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_SHIFT = 2'd1;
  localparam logic [1:0] OP_CAP   = 2'd2;
  localparam logic [1:0] OP_MODE  = 2'd3;

  logic clk = 1'b0;
  logic rstn, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [LW-1:0] cmd_arg;
  logic si_valid, si_ready, so_valid, so_ready;
  logic [NC-1:0] si_data, so_data, csoc_data_o, csoc_data_i, sig;
  logic busy, done, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;

  assign csoc_data_i = csoc_data_o;

  csoc_scan_ctrl #(.NCHAINS(NC), .MAX_LEN(ML), .CLK_DIV(D)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data),
    .busy(busy), .done(done),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
    .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
    .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i),
    .sig(sig)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: command kind plus elapsed-time counters
  int mk = 0, mt = 0, mT = 0, rem = 0, p = 0;
  bit act = 0, m_valid = 0, sov_pre = 0;
  bit e_clk, e_rstn, e_se, e_tm, e_done, e_sov;
  logic [7:0] e_do, e_sod, e_sig;

  int rise_cnt = 0, done_cnt = 0, rlow_cnt = 0, se_bad = 0;
  bit prev_clk = 0;
  logic [7:0] so_got[$];

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(mk == 0));
        chk("busy", 32'(busy), 32'(mk != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("csoc_clk", 32'(csoc_clk), 32'(e_clk));
        chk("csoc_rstn", 32'(csoc_rstn), 32'(e_rstn));
        chk("se", 32'(csoc_test_se), 32'(e_se));
        chk("tm", 32'(csoc_test_tm), 32'(e_tm));
        chk("data_o", 32'(csoc_data_o), 32'(e_do));
        chk("so_valid", 32'(so_valid), 32'(e_sov));
        chk("so_data", 32'(so_data), 32'(e_sod));
        chk("si_ready", 32'(si_ready), 32'(mk == 2 && !act && !e_sov));
`ifdef CSOC_SCAN_SIG_EN
        chk("sig", 32'(sig), 32'(e_sig));
`else
        chk("sig", 32'(sig), 32'h0);
`endif
        if (csoc_clk && !prev_clk) rise_cnt++;
        prev_clk = csoc_clk;
        if (done) done_cnt++;
        if (busy && !csoc_rstn) rlow_cnt++;
        if (mk == 2 && !csoc_test_se) se_bad++;
        if (so_valid && so_ready) so_got.push_back(so_data);
      end
      if (!rstn) begin
        mk = 0; act = 0; m_valid = 1;
        e_clk = 0; e_rstn = 0; e_se = 0; e_tm = 0; e_done = 0;
        e_sov = 0; e_do = 0; e_sod = 0; e_sig = 0;
      end else begin
        sov_pre = e_sov;
        e_done = 0;
        if (e_sov && so_ready) e_sov = 0;
        case (mk)
          0: if (cmd_valid) begin
            case (cmd_op)
              OP_RESET: begin
                mk = 1; mt = 1; mT = 2 * D * (int'(cmd_arg) + 1);
                e_clk = 0; e_rstn = 0;
              end
              OP_SHIFT: begin
                mk = 2; rem = int'(cmd_arg) + 1; act = 0;
                e_se = 1; e_sig = 0;
              end
              OP_CAP: begin
                mk = 3; mt = 1; mT = 2 * D; e_se = 0;
              end
              default: begin
                e_tm = cmd_arg[0]; e_done = 1;
              end
            endcase
          end
          1, 3: begin
            if (mt == mT) begin
              if (mk == 1) e_rstn = 1;
              mk = 0; e_clk = 0; e_done = 1;
            end else begin
              mt++;
              e_clk = (((mt - 1) / D) % 2) == 1;
            end
          end
          2: begin
            if (!act) begin
              if (si_valid && !sov_pre) begin
                act = 1; p = 1; e_do = si_data;
              end
            end else if (p == D) begin
              e_sov = 1; e_sod = e_do;
              e_sig = {e_sig[6:0], e_sig[7]} ^ e_do;
              e_clk = 1; p++;
            end else if (p == 2 * D) begin
              e_clk = 0; act = 0; rem--;
              if (rem == 0) begin
                mk = 0; e_se = 0; e_done = 1;
              end
            end else begin
              p++;
            end
          end
          default: mk = 0;
        endcase
      end
    end
  end

  bit si_rand = 0, so_rand = 0, so_fixed = 1, from_q = 0, hs = 0;
  logic [7:0] si_q[$];

  initial begin
    si_valid = 0; si_data = 0; so_ready = 0;
    forever begin
      @(negedge clk);
      hs = si_valid && si_ready;
      @(posedge clk);
      #1;
      if (hs && from_q && si_q.size() > 0) void'(si_q.pop_front());
      if (si_q.size() > 0) begin
        si_valid = 1; si_data = si_q[0]; from_q = 1;
      end else if (si_rand) begin
        si_valid = ($urandom % 4) != 0; si_data = 8'($urandom); from_q = 0;
      end else begin
        si_valid = 0; from_q = 0;
      end
      so_ready = so_rand ? (($urandom % 3) != 0) : so_fixed;
    end
  end

  task automatic issue(input logic [1:0] op, input int arg);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_op = op; cmd_arg = LW'(arg);
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  int r0, d0, l0, g0, s0, r1, sbad;
  bit sv;
  logic [7:0] exp4[4];
  logic [1:0] rop;
  int rarg;

  initial begin
    rstn = 0; cmd_valid = 0; cmd_op = 0; cmd_arg = 0;
    exp4 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_csoc_rstn", 32'(csoc_rstn), 32'd0);
    chk("rst_so_valid", 32'(so_valid), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);

    r0 = rise_cnt; d0 = done_cnt; l0 = rlow_cnt;
    issue(OP_RESET, 3);
    wait_done(100);
    settle();
    chk("rst3_edges", 32'(rise_cnt - r0), 32'd4);
    chk("rst3_low", 32'(rlow_cnt - l0), 32'd16);
    chk("rst3_done", 32'(done_cnt - d0), 32'd1);
    chk("rst3_rstn", 32'(csoc_rstn), 32'd1);

    so_fixed = 1;
    r0 = rise_cnt; g0 = so_got.size(); s0 = se_bad;
    si_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    issue(OP_SHIFT, 3);
    wait_done(500);
    settle();
    chk("sh_edges", 32'(rise_cnt - r0), 32'd4);
    chk("sh_words", 32'(so_got.size() - g0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("sh_word", 32'(so_got[g0 + i]), 32'(exp4[i]));
    chk("sh_se", 32'(se_bad - s0), 32'd0);

    so_fixed = 0;
    r0 = rise_cnt; g0 = so_got.size();
    si_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    issue(OP_SHIFT, 3);
    sv = 0;
    for (int i = 0; i < 200 && !sv; i++) begin
      @(negedge clk);
      sv = so_valid;
    end
    chk("stall_so_valid", 32'(sv), 32'd1);
    #1;
    r1 = rise_cnt; sbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (si_ready) sbad++;
    end
    #1;
    chk("stall_edges", 32'(rise_cnt - r1), 32'd0);
    chk("stall_si_ready", 32'(sbad), 32'd0);
    chk("stall_clk", 32'(csoc_clk), 32'd0);
    so_fixed = 1;
    wait_done(500);
    settle();
    chk("stall_total_edges", 32'(rise_cnt - r0), 32'd4);
    chk("stall_words", 32'(so_got.size() - g0), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("stall_word", 32'(so_got[g0 + i]), 32'(exp4[i]));

    issue(OP_MODE, 1);
    wait_done(10);
    chk("mode_tm", 32'(csoc_test_tm), 32'd1);
    r0 = rise_cnt; d0 = done_cnt;
    issue(OP_CAP, 0);
    cmd_valid = 1; cmd_op = OP_MODE; cmd_arg = 0;
    repeat (2) @(posedge clk);
    #1 cmd_valid = 0;
    wait_done(20);
    settle();
    chk("cap_edges", 32'(rise_cnt - r0), 32'd1);
    chk("cap_done", 32'(done_cnt - d0), 32'd1);
    chk("cap_tm_kept", 32'(csoc_test_tm), 32'd1);
    chk("cap_se", 32'(csoc_test_se), 32'd0);

    si_q = '{8'h01, 8'h01};
    issue(OP_SHIFT, 1);
    wait_done(200);
    settle();
`ifdef CSOC_SCAN_SIG_EN
    chk("sig_value", 32'(sig), 32'h03);
`else
    chk("sig_value", 32'(sig), 32'h00);
`endif

    r0 = rise_cnt; l0 = rlow_cnt;
    issue(OP_RESET, ML - 1);
    wait_done(5000);
    settle();
    chk("max_edges", 32'(rise_cnt - r0), 32'(ML));
    chk("max_low", 32'(rlow_cnt - l0), 32'(4 * ML));

    d0 = done_cnt;
    si_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    issue(OP_SHIFT, 5);
    repeat (5) @(posedge clk);
    #1 rstn = 0;
    si_q.delete();
    @(posedge clk);
    #1 rstn = 1;
    repeat (30) @(negedge clk);
    #1;
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_so_valid", 32'(so_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    si_rand = 1; so_rand = 1;
    repeat (40) begin
      rop = 2'($urandom % 4);
      rarg = (rop == OP_RESET) ? int'($urandom % 4) :
             (rop == OP_SHIFT) ? int'($urandom % 8) : int'($urandom % 2);
      issue(rop, rarg);
      if ($urandom % 8 == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 rstn = 0;
        @(posedge clk);
        #1 rstn = 1;
      end else begin
        wait_done(2000);
      end
    end
    si_rand = 0; so_rand = 0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csoc_scan_ctrl.md
CSOC_SCAN_CTRL -- requirements
Module: csoc_scan_ctrl

Interface
REQ-001 Parameter NCHAINS, default 8: number of parallel scan chains, 1..8, one bit per chain per shift.
REQ-002 Parameter MAX_LEN, default 1024: maximum shift/reset count; LEN_W = $clog2(MAX_LEN).
REQ-003 Parameter CLK_DIV, default 2: clk cycles per csoc_clk half-period, minimum 1.
REQ-004 clk  in  1  system clock; sole clock, all logic on posedge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command strobe.
REQ-007 cmd_ready  out  1  high whenever FSM is IDLE.
REQ-008 cmd_op  in  2  opcode: 0 RESET, 1 SHIFT, 2 CAPTURE, 3 MODE.
REQ-009 cmd_arg  in  LEN_W  count-1 for RESET and SHIFT; bit0 = tm value for MODE.
REQ-010 si_valid / si_ready / si_data  in/out/in  1/1/NCHAINS  scan-in word stream.
REQ-011 so_valid / so_ready / so_data  out/in/out  1/1/NCHAINS  scan-out word stream, 1-deep register.
REQ-012 busy  out  1  FSM not IDLE; done  out  1  one-cycle pulse on return to IDLE.
REQ-013 csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm  out  1 each  registered CSoC controls.
REQ-014 csoc_data_o  out  NCHAINS  scan-in to chains; csoc_data_i  in  NCHAINS  scan-out from chains.
REQ-015 sig  out  NCHAINS  scan-out signature (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, RST_LO, RST_HI, SH_WAIT, SH_LO, SH_HI, CAP_LO, CAP_HI.
REQ-017 Command SHALL be accepted only on cmd_valid && cmd_ready; cmd_valid while busy SHALL be ignored.
REQ-018 RESET: csoc_rstn=0, csoc_clk toggles (CLK_DIV low, CLK_DIV high) for cmd_arg+1 periods, then csoc_rstn=1, IDLE.
REQ-019 SHIFT: csoc_test_se=1 from accept until IDLE; exactly cmd_arg+1 csoc_clk rising edges.
REQ-020 SH_WAIT: si_ready=1 only when so slot empty (so_valid=0); csoc_clk held 0 while stalled.
REQ-021 On si handshake: csoc_data_o <= si_data, enter SH_LO for CLK_DIV cycles with csoc_clk=0.
REQ-022 Last SH_LO cycle: so_data <= csoc_data_i, so_valid <= 1; then SH_HI for CLK_DIV cycles with csoc_clk=1.
REQ-023 so_valid SHALL hold until so_ready; so_data stable while so_valid && !so_ready.
REQ-024 After final SH_HI: csoc_test_se=0, done pulse, IDLE; pending so word remains valid until consumed.
REQ-025 CAPTURE: csoc_test_se=0, one csoc_clk period (CAP_LO, CAP_HI), done, IDLE.
REQ-026 MODE: csoc_test_tm <= cmd_arg[0] in accept cycle; done next cycle; no csoc_clk edge.
REQ-027 Shift/reset counters LEN_W wide, count down to 0; cmd_arg=MAX_LEN-1 SHALL yield MAX_LEN periods, no wrap.
REQ-028 csoc_clk SHALL never glitch: changes only at phase boundaries, min pulse CLK_DIV clk cycles.

Reset
REQ-029 rstn=0 at posedge clk: IDLE, csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_data_o=0, so_valid=0, so_data=0, sig=0, busy=0, done=0.
REQ-030 Reset mid-operation SHALL abandon the command, discard any pending so word, and not emit done.
REQ-031 cmd_ready=1 the first cycle rstn is high.

Configuration
REQ-032 Macro CSOC_SCAN_SIG_EN defined: on each so sample, sig <= rotl1(sig) ^ sampled word; sig cleared on SHIFT accept.
REQ-033 CSOC_SCAN_SIG_EN undefined: sig tied to 0, no signature logic; all other behaviour identical.

Verification (NCHAINS=8, CLK_DIV=2, loopback csoc_data_i=csoc_data_o unless stated)
REQ-034 rstn low 3 cycles -> all REQ-029 values, cmd_ready=1 after release.
REQ-035 RESET arg=3 -> csoc_rstn low for 16 clk cycles with 4 csoc_clk rising edges, then 1; one done pulse.
REQ-036 SHIFT arg=3, si 0xA5,0x3C,0xFF,0x00, so_ready=1 -> so 0xA5,0x3C,0xFF,0x00; se=1 throughout; exactly 4 rising edges.
REQ-037 Same SHIFT, so_ready=0 for 20 cycles after first so word -> csoc_clk stays 0, si_ready=0, no extra edge; resumes correctly.
REQ-038 MODE arg=1 then CAPTURE -> tm=1, single csoc_clk pulse with se=0; cmd_valid during CAPTURE ignored.
REQ-039 CSOC_SCAN_SIG_EN: SHIFT arg=1, si 0x01,0x01 -> sig=0x03; without macro sig=0x00.
